// File: rtl/mem_access.sv
// mem_access -- memory-access stage of the RV64 pipeline.
//
// Takes one execute result at a time, issues at most one data-bus request
// per load/store over a split address/data handshake, aligns store data and
// byte strobes onto the 8-byte lane, extracts and extends load data, and
// presents a single registered result to writeback for one cycle.
// Non-memory instructions pass straight through to the result register.
//
// Handshakes: an instruction is taken when in_valid && in_ready (in_ready is
// high only in IDLE). A bus request is offered while dreq_valid is high and
// is taken when dresp_addr_ok is high in that cycle; its completion is the
// first dresp_data_ok at or after acceptance. dresp_* are ignored outside
// REQ/WAIT. out_valid is a one-cycle pulse; downstream never stalls.
//
// Optional build macro: MEM_MISALIGN_TRAP_EN
//   defined   : misaligned load/store skips the bus, completes with out_exc=1
//               and out_result=0.
//   undefined : out_exc is tied low and the address is forced to natural
//               alignment before the access.
//
// Ports:
//   clk, resetn                      clock, synchronous active-low reset
//   in_valid/in_ready                execute-side handshake
//   in_pc, in_addr, in_wdata         PC, ALU result / address, store data
//   in_memread, in_memwrite          load / store select
//   in_size, in_unsigned             access size (0..3 = B/H/W/D), zero-extend
//   dreq_valid/addr/size/strobe/data bus request
//   dresp_addr_ok/data_ok/data       bus response
//   out_valid/pc/result/exc          writeback result

module mem_access #(
   parameter int XLEN   = 64,
   parameter int STRB_W = XLEN / 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [XLEN-1:0]   in_addr,
   input  logic [XLEN-1:0]   in_wdata,
   input  logic              in_memread,
   input  logic              in_memwrite,
   input  logic [1:0]        in_size,
   input  logic              in_unsigned,
   output logic              dreq_valid,
   output logic [XLEN-1:0]   dreq_addr,
   output logic [1:0]        dreq_size,
   output logic [STRB_W-1:0] dreq_strobe,
   output logic [XLEN-1:0]   dreq_data,
   input  logic              dresp_addr_ok,
   input  logic              dresp_data_ok,
   input  logic [XLEN-1:0]   dresp_data,
   output logic              out_valid,
   output logic [XLEN-1:0]   out_pc,
   output logic [XLEN-1:0]   out_result,
   output logic              out_exc
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   pc_q, addr_q, wdata_q, result_q;
   logic [1:0]        size_q;
   logic              memread_q, memwrite_q, unsigned_q;

   logic              accept, is_mem_in, trap_in, load_done;
   logic [2:0]        in_mask, off;
   logic [7:0]        base_strobe;
   logic [XLEN-1:0]   shifted, load_val;

   // Low address bits that must be zero for a naturally aligned access.
   function automatic logic [2:0] low_mask(input logic [1:0] size);
      case (size)
         2'd0:    return 3'b000;
         2'd1:    return 3'b001;
         2'd2:    return 3'b011;
         default: return 3'b111;
      endcase
   endfunction

   assign accept    = in_valid && (state_q == IDLE);
   assign is_mem_in = in_memread || in_memwrite;
   assign in_mask   = low_mask(in_size);

`ifdef MEM_MISALIGN_TRAP_EN
   logic exc_q;
   assign trap_in = is_mem_in && ((in_addr[2:0] & in_mask) != 3'b000);
`else
   assign trap_in = 1'b0;
`endif

   // Load result is taken on the edge where the data phase completes.
   assign load_done = dresp_data_ok && memread_q &&
                      ((state_q == WAIT) || (state_q == REQ && dresp_addr_ok));

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = (!is_mem_in || trap_in) ? DONE : REQ;
         REQ:  if (dresp_addr_ok) state_d = dresp_data_ok ? DONE : WAIT;
         WAIT: if (dresp_data_ok) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- lane alignment / extraction ----------------
   assign off = addr_q[2:0];

   always_comb begin
      base_strobe = 8'hFF;
      case (size_q)
         2'd0:    base_strobe = 8'h01;
         2'd1:    base_strobe = 8'h03;
         2'd2:    base_strobe = 8'h0F;
         default: base_strobe = 8'hFF;
      endcase
   end

   assign shifted = dresp_data >> {off, 3'b000};

   always_comb begin
      load_val = shifted;
      case (size_q)
         2'd0: load_val = {{56{~unsigned_q & shifted[7]}},  shifted[7:0]};
         2'd1: load_val = {{48{~unsigned_q & shifted[15]}}, shifted[15:0]};
         2'd2: load_val = {{32{~unsigned_q & shifted[31]}}, shifted[31:0]};
         default: load_val = shifted;   // dword ignores in_unsigned
      endcase
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= IDLE;
         pc_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         result_q   <= '0;
         size_q     <= 2'd0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
         unsigned_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            pc_q       <= in_pc;
            // Without trapping this forces natural alignment; with trapping
            // only aligned addresses ever reach the bus, so it is a no-op.
            addr_q     <= in_addr & ~{{(XLEN-3){1'b0}}, in_mask};
            wdata_q    <= in_wdata;
            size_q     <= in_size;
            memread_q  <= in_memread;
            memwrite_q <= in_memwrite;
            unsigned_q <= in_unsigned;
            result_q   <= is_mem_in ? '0 : in_addr;
         end else if (load_done) begin
            result_q <= load_val;
         end
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   always_ff @(posedge clk) begin
      if (!resetn)     exc_q <= 1'b0;
      else if (accept) exc_q <= trap_in;
   end
   assign out_exc = out_valid && exc_q;
`else
   assign out_exc = 1'b0;
`endif

   // ---------------- outputs ----------------
   assign in_ready    = (state_q == IDLE);
   assign dreq_valid  = (state_q == REQ);
   assign dreq_addr   = dreq_valid ? addr_q : '0;
   assign dreq_size   = dreq_valid ? size_q : 2'd0;
   assign dreq_strobe = (dreq_valid && memwrite_q) ? STRB_W'(base_strobe << off) : '0;
   assign dreq_data   = (dreq_valid && memwrite_q) ? (wdata_q << {off, 3'b000}) : '0;
   assign out_valid   = (state_q == DONE);
   assign out_pc      = out_valid ? pc_q : '0;
   assign out_result  = out_valid ? result_q : '0;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access -- randomized self-checking bench for mem_access.
//
// A driver issues one instruction at a time and plays the bus slave with a
// chosen addr_ok / data_ok delay. Expected bus requests and results come
// from byte-level model functions; a compare process checks dreq_* and
// out_* on every falling edge. Build with +define+MEM_MISALIGN_TRAP_EN to
// check the trapping variant.

module tb_mem_access;

   logic        clk = 1'b0;
   logic        resetn;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_pc, in_addr, in_wdata;
   logic        in_memread, in_memwrite;
   logic [1:0]  in_size;
   logic        in_unsigned;
   logic        dreq_valid;
   logic [63:0] dreq_addr;
   logic [1:0]  dreq_size;
   logic [7:0]  dreq_strobe;
   logic [63:0] dreq_data;
   logic        dresp_addr_ok, dresp_data_ok;
   logic [63:0] dresp_data;
   logic        out_valid;
   logic [63:0] out_pc, out_result;
   logic        out_exc;

   mem_access dut (
      .clk(clk), .resetn(resetn),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_addr(in_addr), .in_wdata(in_wdata),
      .in_memread(in_memread), .in_memwrite(in_memwrite),
      .in_size(in_size), .in_unsigned(in_unsigned),
      .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
      .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
      .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
      .dresp_data(dresp_data),
      .out_valid(out_valid), .out_pc(out_pc), .out_result(out_result),
      .out_exc(out_exc)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int checks   = 0;
   int failures = 0;
   logic [128:0] exp_q[$];        // {exc, pc, result}
   logic [128:0] cmp_e;
   logic         run_chk = 1'b0;
   logic         exp_req = 1'b0;
   logic         exp_ov  = 1'b0;
   logic [63:0]  exp_addr, exp_data;
   logic [1:0]   exp_size;
   logic [7:0]   exp_strobe;

`ifdef MEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [63:0] f_align(input logic [63:0] a, input logic [1:0] s);
      logic [63:0] nb = 64'd1 << s;
      return a - (a % nb);
   endfunction

   function automatic logic [7:0] f_strobe(input logic [63:0] a, input logic [1:0] s);
      logic [7:0] st = '0;
      int nb = 1 << s;
      int off = int'(a[2:0]);
      for (int i = 0; i < nb; i++) if (off + i < 8) st[off + i] = 1'b1;
      return st;
   endfunction

   function automatic logic [63:0] f_wdata(input logic [63:0] w, input logic [63:0] a);
      logic [63:0] d = '0;
      int off = int'(a[2:0]);
      for (int j = 0; j < 8; j++) if (j >= off) d[8*j +: 8] = w[8*(j-off) +: 8];
      return d;
   endfunction

   function automatic logic [63:0] f_load(input logic [63:0] a, input logic [1:0] s,
                                          input logic u, input logic [63:0] d);
      logic [63:0] r = '0;
      int nb = 1 << s;
      int off = int'(a[2:0]);
      for (int i = 0; i < nb; i++) if (off + i < 8) r[8*i +: 8] = d[8*(off+i) +: 8];
      if (!u && nb < 8 && r[8*nb-1])
         for (int i = nb; i < 8; i++) r[8*i +: 8] = 8'hFF;
      return r;
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (run_chk && resetn) begin
         chk("dreq_valid", {63'b0, dreq_valid}, {63'b0, exp_req});
         if (exp_req && dreq_valid) begin
            chk("dreq_addr", dreq_addr, exp_addr);
            chk("dreq_size", {62'b0, dreq_size}, {62'b0, exp_size});
            chk("dreq_strobe", {56'b0, dreq_strobe}, {56'b0, exp_strobe});
            chk("dreq_data", dreq_data, exp_data);
         end
         chk("out_valid", {63'b0, out_valid}, {63'b0, exp_ov});
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("out_unexpected", 64'd1, 64'd0);
            end else begin
               cmp_e = exp_q.pop_front();
               chk("out_pc", out_pc, cmp_e[127:64]);
               chk("out_result", out_result, cmp_e[63:0]);
               chk("out_exc", {63'b0, out_exc}, {63'b0, cmp_e[128]});
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [63:0] pc, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic rd, input logic wr,
                         input logic [1:0] size, input logic uns,
                         input int a_dly, input int d_dly, input logic [63:0] rdata,
                         input logic use_lit, input logic [63:0] lit);
      logic [63:0] eff, res, nb;
      logic        mis, trap, mem;
      int          n;
      nb   = 64'd1 << size;
      mis  = (addr % nb) != 0;
      trap = TRAP && (rd || wr) && mis;
      mem  = (rd || wr) && !trap;
      eff  = f_align(addr, size);
      if (trap)    res = '0;
      else if (rd) res = f_load(eff, size, uns, rdata);
      else if (wr) res = '0;
      else         res = addr;
      if (use_lit) chk("model_pin", res, lit);
      exp_q.push_back({trap, pc, res});

      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      if (!in_ready) chk("ready_timeout", 64'd0, 64'd1);

      in_valid = 1'b1; in_pc = pc; in_addr = addr; in_wdata = wdata;
      in_memread = rd; in_memwrite = wr; in_size = size; in_unsigned = uns;
      tick();
      // Scramble the inputs: the stage must work from its captured copy.
      in_valid = 1'b0; in_pc = {$urandom, $urandom}; in_addr = {$urandom, $urandom};
      in_wdata = {$urandom, $urandom}; in_size = 2'($urandom_range(0, 3));
      in_unsigned = 1'($urandom_range(0, 1));
      in_memread = 1'($urandom_range(0, 1)); in_memwrite = ~in_memread;

      if (!mem) begin
         exp_ov = 1'b1;
         tick();
         exp_ov = 1'b0;
      end else begin
         exp_req    = 1'b1;
         exp_addr   = eff;
         exp_size   = size;
         exp_strobe = wr ? f_strobe(eff, size) : 8'h00;
         exp_data   = wr ? f_wdata(wdata, eff) : 64'h0;
         repeat (a_dly) tick();
         dresp_addr_ok = 1'b1;
         if (d_dly == 0) begin
            dresp_data_ok = 1'b1;
            dresp_data    = rdata;
         end
         tick();
         exp_req = 1'b0;
         dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = {$urandom, $urandom};
         if (d_dly > 0) begin
            repeat (d_dly - 1) tick();
            dresp_data_ok = 1'b1;
            dresp_data    = rdata;
            tick();
            dresp_data_ok = 1'b0; dresp_data = {$urandom, $urandom};
         end
         exp_ov = 1'b1;
         tick();
         exp_ov = 1'b0;
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [63:0] a, w, d;
      logic        rd, wr;
      int          kind;

      resetn = 1'b0; in_valid = 1'b0; in_pc = '0; in_addr = '0; in_wdata = '0;
      in_memread = 1'b0; in_memwrite = 1'b0; in_size = 2'd0; in_unsigned = 1'b0;
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
      tick();
      tick();

      // reset state
      chk("rst_in_ready",   {63'b0, in_ready},   64'd1);
      chk("rst_dreq_valid", {63'b0, dreq_valid}, 64'd0);
      chk("rst_dreq_addr",  dreq_addr,           64'd0);
      chk("rst_dreq_strobe",{56'b0, dreq_strobe},64'd0);
      chk("rst_out_valid",  {63'b0, out_valid},  64'd0);
      chk("rst_out_result", out_result,          64'd0);
      chk("rst_out_exc",    {63'b0, out_exc},    64'd0);

      // model pins
      chk("pin_strobe_sw", {56'b0, f_strobe(64'h80001004, 2'd2)}, 64'hF0);
      chk("pin_wdata_sw",  f_wdata(64'hDEADBEEF, 64'h80001004), 64'hDEADBEEF_00000000);
      chk("pin_align_lh",  f_align(64'h80001001, 2'd1), 64'h80001000);

      resetn  = 1'b1;
      run_chk = 1'b1;

      // non-memory pass-through
      run_op(64'h80000000, 64'h1234, 64'h0, 1'b0, 1'b0, 2'd3, 1'b0, 0, 0, 64'h0,
             1'b1, 64'h1234);
      // SW with addr_ok held low 3 cycles, then addr_ok & data_ok together
      run_op(64'h80000004, 64'h80001004, 64'hDEADBEEF, 1'b0, 1'b1, 2'd2, 1'b0, 3, 0,
             64'h0, 1'b1, 64'h0);
      // LB offset 3, 2-cycle WAIT, signed then unsigned
      run_op(64'h80000008, 64'h80000003, 64'h0, 1'b1, 1'b0, 2'd0, 1'b0, 0, 2,
             64'h00000000_80000000, 1'b1, 64'hFFFFFFFF_FFFFFF80);
      run_op(64'h8000000C, 64'h80000003, 64'h0, 1'b1, 1'b0, 2'd0, 1'b1, 0, 2,
             64'h00000000_80000000, 1'b1, 64'h80);
      // LD, signed and unsigned
      run_op(64'h80000010, 64'h80002000, 64'h0, 1'b1, 1'b0, 2'd3, 1'b0, 1, 1,
             64'h01234567_89ABCDEF, 1'b1, 64'h01234567_89ABCDEF);
      run_op(64'h80000014, 64'h80002000, 64'h0, 1'b1, 1'b0, 2'd3, 1'b1, 0, 0,
             64'h01234567_89ABCDEF, 1'b1, 64'h01234567_89ABCDEF);

      // reset in WAIT: bus transaction abandoned, stray data_ok ignored
      in_valid = 1'b1; in_pc = 64'h80000018; in_addr = 64'h80003000;
      in_memread = 1'b1; in_memwrite = 1'b0; in_size = 2'd2; in_unsigned = 1'b0;
      tick();
      in_valid = 1'b0;
      exp_req = 1'b1; exp_addr = 64'h80003000; exp_size = 2'd2;
      exp_strobe = 8'h00; exp_data = 64'h0;
      dresp_addr_ok = 1'b1;
      tick();
      dresp_addr_ok = 1'b0;
      exp_req = 1'b0;
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      chk("rstwait_in_ready",   {63'b0, in_ready},   64'd1);
      chk("rstwait_dreq_valid", {63'b0, dreq_valid}, 64'd0);
      dresp_data_ok = 1'b1; dresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      dresp_data_ok = 1'b0;
      tick();
      tick();
      chk("rstwait_out_valid", {63'b0, out_valid}, 64'd0);

      // misaligned LH
      run_op(64'h8000001C, 64'h80001001, 64'h0, 1'b1, 1'b0, 2'd1, 1'b0, 0, 1,
             64'h00000000_0000BEEF, 1'b1, TRAP ? 64'h0 : 64'hFFFFFFFF_FFFFBEEF);

      // randomized traffic
      for (int k = 0; k < 250; k++) begin
         kind = $urandom_range(0, 2);
         rd = (kind == 1);
         wr = (kind == 2);
         a  = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 1) a[2:0] = 3'b000;
         w  = {$urandom, $urandom};
         d  = {$urandom, $urandom};
         run_op({$urandom, $urandom}, a, w, rd, wr, 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                d, 1'b0, 64'h0);
      end

      tick();
      tick();
      chk("queue_drain", 64'(exp_q.size()), 64'd0);
      run_chk = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
